// File: rtl/falling_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : falling_edge_detector
//  Purpose  : Per-channel falling-edge detector with an optional input
//             synchronizer, programmable-length registered output pulses
//             and a saturating edge counter summed over all channels.
//  Revision : 1.0  initial release
// ============================================================================
module falling_edge_detector #(
    parameter int WIDTH        = 1,   // number of independent channels
    parameter int SYNC_STAGES  = 0,   // synchronizer depth, 0..4
    parameter int PULSE_CYCLES = 1,   // pulse length in cycles, >= 1
    parameter int CNT_W        = 16   // edge counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] pulse,
    output logic [CNT_W-1:0] edge_cnt
);

    // Stretch counter holds the number of pulse cycles still owed after the
    // current one, so it needs to represent PULSE_CYCLES-1 at most.
    localparam int c_stretch_w = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [c_stretch_w-1:0] c_reload = c_stretch_w'(PULSE_CYCLES - 1);

    // Popcount width and a sum width wide enough that count + popcount
    // can never overflow before the saturation compare.
    localparam int c_pop_w = $clog2(WIDTH + 1);
    localparam int c_sum_w = ((CNT_W > c_pop_w) ? CNT_W : c_pop_w) + 1;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [WIDTH-1:0]       w_s;        // synchronized input
    logic [WIDTH-1:0]       r_prev;     // previous sample of w_s
    logic [WIDTH-1:0]       w_fall;     // falling edge seen this cycle
    logic [WIDTH-1:0]       r_pulse;
    logic [c_stretch_w-1:0] r_stretch [WIDTH];
    logic [CNT_W-1:0]       r_edge_cnt;
    logic [c_pop_w-1:0]     w_pop;
    logic [c_sum_w-1:0]     w_sum;
    logic [CNT_W-1:0]       w_cnt_next;

    // ------------------------------------------------------------------
    // Optional synchronizer chain
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] r_sync [SYNC_STAGES];

            // Shift the raw inputs through SYNC_STAGES flops.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= '0;
                    end
                end else begin
                    r_sync[0] <= in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_s = in;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    // A fall is a 1 in the previous sample followed by a 0 now; the reset
    // value of 0 means neither a high nor a low level at release fires.
    assign w_fall = r_prev & ~w_s;

    // Remember last cycle's synchronized sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_s;
        end
    end

    // ------------------------------------------------------------------
    // Pulse stretching
    // ------------------------------------------------------------------
    // A fall raises the pulse and (re)loads the owed-cycle count; otherwise
    // the pulse holds while cycles are still owed, then drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_stretch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_fall[i]) begin
                    r_pulse[i]   <= 1'b1;
                    r_stretch[i] <= c_reload;
                end else if (r_stretch[i] != '0) begin
                    r_pulse[i]   <= 1'b1;
                    r_stretch[i] <= r_stretch[i] - 1'b1;
                end else begin
                    r_pulse[i]   <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating edge counter
    // ------------------------------------------------------------------
    // Count falls this cycle and form the saturated next count.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_pop_w'(w_fall[i]);
        end
        w_sum = c_sum_w'(r_edge_cnt) + c_sum_w'(w_pop);
        if (w_sum > c_sum_w'(c_cnt_max)) begin
            w_cnt_next = c_cnt_max;
        end else begin
            w_cnt_next = w_sum[CNT_W-1:0];
        end
    end

    // Register the edge count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= w_cnt_next;
        end
    end

    assign pulse    = r_pulse;
    assign edge_cnt = r_edge_cnt;

endmodule
`default_nettype wire

// File: tb/tb_falling_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_falling_edge_detector
//  Purpose  : Directed self-checking bench for falling_edge_detector using
//             four differently parameterized instances on a shared clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_falling_edge_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [0:0]  in_a = 1'b1, pulse_a;   // WIDTH=1, P=1, S=0
    logic [15:0] cnt_a;
    logic [0:0]  in_b = 1'b1, pulse_b;   // WIDTH=1, P=4
    logic [15:0] cnt_b;
    logic [0:0]  in_c = 1'b1, pulse_c;   // WIDTH=1, S=2
    logic [15:0] cnt_c;
    logic [3:0]  in_d = 4'hF, pulse_d;   // WIDTH=4, CNT_W=3
    logic [2:0]  cnt_d;

    int n_total = 0;
    int n_bad   = 0;

    always #10 clk = ~clk;   // 50 MHz

    falling_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .PULSE_CYCLES(1), .CNT_W(16))
        u_dut_a (.clk(clk), .rst(rst), .in(in_a), .pulse(pulse_a), .edge_cnt(cnt_a));
    falling_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .PULSE_CYCLES(4), .CNT_W(16))
        u_dut_b (.clk(clk), .rst(rst), .in(in_b), .pulse(pulse_b), .edge_cnt(cnt_b));
    falling_edge_detector #(.WIDTH(1), .SYNC_STAGES(2), .PULSE_CYCLES(1), .CNT_W(16))
        u_dut_c (.clk(clk), .rst(rst), .in(in_c), .pulse(pulse_c), .edge_cnt(cnt_c));
    falling_edge_detector #(.WIDTH(4), .SYNC_STAGES(0), .PULSE_CYCLES(1), .CNT_W(3))
        u_dut_d (.clk(clk), .rst(rst), .in(in_d), .pulse(pulse_d), .edge_cnt(cnt_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Dwell table for the toggle test: levels alternate 1,0,1,0,... starting
    // from a low input, so the 5 low segments each open with one pulse.
    int dwell [10] = '{3, 2, 5, 1, 1, 4, 10, 2, 2, 6};

    initial begin
        // ---------------- reset, inputs held high -------------------------
        step();
        chk("rst_pulse_a", 32'(pulse_a), 32'd0);
        chk("rst_pulse_d", 32'(pulse_d), 32'd0);
        chk("rst_cnt_a",   32'(cnt_a),   32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rel_pulse_a", 32'(pulse_a), 32'd0);
            chk("rel_pulse_c", 32'(pulse_c), 32'd0);
            chk("rel_cnt_a",   32'(cnt_a),   32'd0);
        end

        // ---------------- basic edge on channel A -------------------------
        in_a = 1'b0;
        step(); chk("basic_fall", 32'(pulse_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); chk("basic_low", 32'(pulse_a), 32'd0);
        end
        in_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("basic_rise", 32'(pulse_a), 32'd0);
        end
        in_a = 1'b0;
        step(); chk("basic_fall2", 32'(pulse_a), 32'd1);
        step(); chk("basic_after", 32'(pulse_a), 32'd0);
        chk("basic_cnt", 32'(cnt_a), 32'd2);

        // ---------------- toggle table on channel A -----------------------
        for (int t = 0; t < 10; t++) begin
            in_a = (t % 2 == 0) ? 1'b1 : 1'b0;
            for (int j = 0; j < dwell[t]; j++) begin
                step();
                chk("toggle_pulse", 32'(pulse_a), (in_a == 1'b0 && j == 0) ? 32'd1 : 32'd0);
            end
        end
        chk("toggle_cnt", 32'(cnt_a), 32'd7);

        // ---------------- stretch + retrigger on channel B ---------------
        in_b = 1'b0; step(); chk("stretch_k0", 32'(pulse_b), 32'd1);
        in_b = 1'b1; step(); chk("stretch_k1", 32'(pulse_b), 32'd1);
        in_b = 1'b0; step(); chk("stretch_k2", 32'(pulse_b), 32'd1);
        for (int i = 3; i < 6; i++) begin
            step(); chk("stretch_hold", 32'(pulse_b), 32'd1);
        end
        step(); chk("stretch_end", 32'(pulse_b), 32'd0);
        step(); chk("stretch_end2", 32'(pulse_b), 32'd0);
        chk("stretch_cnt", 32'(cnt_b), 32'd2);

        // ---------------- synchronizer latency on channel C --------------
        in_c = 1'b0;
        step(); chk("sync_k0", 32'(pulse_c), 32'd0);
        step(); chk("sync_k1", 32'(pulse_c), 32'd0);
        step(); chk("sync_k2", 32'(pulse_c), 32'd1);
        step(); chk("sync_k3", 32'(pulse_c), 32'd0);
        chk("sync_cnt", 32'(cnt_c), 32'd1);

        // ---------------- multi-channel + saturation on D ----------------
        in_d = 4'h0;
        step(); chk("multi_pulse", 32'(pulse_d), 32'hF);
        chk("multi_cnt", 32'(cnt_d), 32'd4);
        step(); chk("multi_off", 32'(pulse_d), 32'h0);
        in_d = 4'hF;
        step(); chk("multi_rise", 32'(pulse_d), 32'h0);
        in_d = 4'h0;
        step(); chk("sat_pulse", 32'(pulse_d), 32'hF);
        chk("sat_cnt", 32'(cnt_d), 32'd7);
        in_d = 4'hF; step();
        in_d = 4'h0; step();
        chk("sat_hold_pulse", 32'(pulse_d), 32'hF);
        chk("sat_hold_cnt", 32'(cnt_d), 32'd7);

        // ---------------- asynchronous reset mid-pulse -------------------
        #2 rst = 1'b1;
        #1;
        chk("arst_pulse", 32'(pulse_d), 32'h0);
        chk("arst_cnt",   32'(cnt_d),   32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_pulse", 32'(pulse_d), 32'h0);
            chk("post_rst_cnt",   32'(cnt_d),   32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
